// File: rtl/vec_mem_pkg.sv
// ---------------------------------------------------------------------------
// vec_mem_pkg
// Shared definitions for the vector load/store sequencer:
//   - default parameter values for the sequencer and its load FIFO
//   - the sequencer state encoding
// ---------------------------------------------------------------------------
package vec_mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
    localparam int DEF_LEN_WIDTH  = 6;
    localparam int DEF_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/vec_ld_fifo.sv
// ---------------------------------------------------------------------------
// vec_ld_fifo
// Small synchronous FIFO that holds SRAM read data on its way back to the
// vector unit. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset, empties the FIFO
//   i_push   write i_data this cycle
//   i_data   write data
//   i_pop    consumer takes the head entry (ignored while empty)
//   o_valid  FIFO not empty
//   o_data   head entry
//   o_count  number of stored entries
// ---------------------------------------------------------------------------
module vec_ld_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CNT_WIDTH-1:0]  o_count
);

    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, pointers and occupancy; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The sequencer's credit scheme must never push into a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_push && !w_pop && (r_count == CNT_WIDTH'(DEPTH))))
                else $error("vec_ld_fifo overflow");
        end
    end

endmodule

// File: rtl/vec_mem_seq.sv
// ---------------------------------------------------------------------------
// vec_mem_seq
// Vector load/store sequencer in front of a 1RW1R SRAM macro. One strided
// request at a time is expanded into per-element SRAM accesses: stores go
// out on port 0 (RW) as store data arrives, loads are issued on port 1 (R)
// and their data returns through a credit-managed FIFO.
// Ports:
//   clk0, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we/base/stride/len/wmask     request fields (len 0 = no-op)
//   st_valid/st_ready/st_data        store element stream
//   ld_valid/ld_ready/ld_data        load element stream (FIFO head)
//   done                             one-cycle completion pulse
//   csb0/web0/wmask0/addr0/din0      SRAM port 0 (active-low select/we)
//   csb1/addr1/dout1                 SRAM port 1, dout1 valid a cycle later
// ---------------------------------------------------------------------------
module vec_mem_seq
    import vec_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [ADDR_WIDTH-1:0] req_stride,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  done,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic                  r_inflight;
    logic                  r_done;

    logic                  w_req_fire;
    logic                  w_st_fire;
    logic                  w_pop;
    logic                  w_credit;
    logic                  w_issue;
    logic [CNT_WIDTH-1:0]  w_fifo_count;

    assign req_ready  = (r_state == IDLE);
    assign st_ready   = (r_state == STORE);
    assign done       = r_done;
    assign w_req_fire = req_valid && req_ready;
    assign w_st_fire  = st_valid && st_ready;
    assign w_pop      = ld_valid && ld_ready;

    // Occupancy seen by the next push is fifo + in-flight read minus the pop
    // happening now; counting the pop lets loads stream at one per cycle
    // through a two-entry FIFO without ever overflowing it.
    assign w_credit = (int'(w_fifo_count) + int'(r_inflight) - int'(w_pop)) < FIFO_DEPTH;
    assign w_issue  = (r_state == LOAD) && (r_remain != '0) && w_credit;

    // Port 0 is driven straight from the store handshake so the write lands
    // in the same cycle; idle values are the reset values.
    assign csb0   = !w_st_fire;
    assign web0   = !w_st_fire;
    assign addr0  = w_st_fire ? r_cur_addr : '0;
    assign din0   = w_st_fire ? st_data    : '0;
    assign wmask0 = w_st_fire ? r_wmask    : '0;

    assign csb1   = !w_issue;
    assign addr1  = w_issue ? r_cur_addr : '0;

    // Request sequencing: latch the request, step the address per element,
    // and raise done for one cycle once the last element has been handled.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cur_addr <= '0;
            r_stride   <= '0;
            r_remain   <= '0;
            r_wmask    <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_cur_addr <= req_base;
                        r_stride   <= req_stride;
                        r_remain   <= req_len;
                        r_wmask    <= req_wmask;
                        if (req_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= req_we ? STORE : LOAD;
                        end
                    end
                end
                STORE: begin
                    if (w_st_fire) begin
                        r_cur_addr <= r_cur_addr + r_stride;
                        r_remain   <= r_remain - LEN_WIDTH'(1);
                        if (r_remain == LEN_WIDTH'(1)) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_issue) begin
                        r_cur_addr <= r_cur_addr + r_stride;
                        r_remain   <= r_remain - LEN_WIDTH'(1);
                        if (r_remain == LEN_WIDTH'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_inflight && (w_fifo_count == '0)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    vec_ld_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_ld_fifo (
        .clk     (clk0),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (dout1),
        .i_pop   (ld_ready),
        .o_valid (ld_valid),
        .o_data  (ld_data),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_vec_mem_seq.sv
// ---------------------------------------------------------------------------
// tb_vec_mem_seq
// Directed bench for vec_mem_seq with a behavioural SRAM, a request-level
// expectation model and a per-cycle compare process.
// ---------------------------------------------------------------------------
module tb_vec_mem_seq;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  m;
    } stExp_t;

    logic        clk0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_base;
    logic [7:0]  req_stride;
    logic [5:0]  req_len;
    logic [3:0]  req_wmask;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        done;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout1;

    int          nChecks;
    int          nPass;
    int          cycleCount;
    int          issuedCount;
    int          poppedCount;
    logic        ldReadyMode;

    logic [31:0] sramMem [256];
    logic [31:0] refMem  [256];
    stExp_t      expStQ[$];
    logic [7:0]  expLdAddrQ[$];
    logic [31:0] expLdDataQ[$];
    logic [31:0] stDataQ[$];
    logic [7:0]  stAddrLog[$];
    logic [7:0]  ldAddrLog[$];
    logic [31:0] ldDataLog[$];

    vec_mem_seq dut (
        .clk0       (clk0),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_len    (req_len),
        .req_wmask  (req_wmask),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_data    (st_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .done       (done),
        .csb0       (csb0),
        .web0       (web0),
        .wmask0     (wmask0),
        .addr0      (addr0),
        .din0       (din0),
        .csb1       (csb1),
        .addr1      (addr1),
        .dout1      (dout1)
    );

    // Free-running clock and cycle counter.
    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    initial begin
        cycleCount = 0;
        forever begin
            @(posedge clk0);
            cycleCount++;
        end
    end

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW,
                                               input logic [31:0] newW,
                                               input logic [3:0]  m);
        logic [31:0] r;
        r = oldW;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = newW[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM macro: masked write on port 0, registered read on port 1.
    always @(posedge clk0) begin
        if (!csb0 && !web0) sramMem[addr0] <= mergeBytes(sramMem[addr0], din0, wmask0);
        if (!csb1) dout1 <= sramMem[addr1];
    end

    // Consumer: always ready, or ready one cycle in three.
    initial begin
        ld_ready = 1'b1;
        forever begin
            @(posedge clk0);
            #1;
            ld_ready = ldReadyMode ? ((cycleCount % 3) == 0) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycleCount);
        end
    endtask

    // Request-level model: element i lives at base + i*stride modulo 256.
    task automatic buildExpect(input logic we, input logic [7:0] base, input logic [7:0] stride,
                               input int len, input logic [3:0] mask);
        for (int i = 0; i < len; i++) begin
            logic [7:0] a;
            stExp_t     e;
            a = base + 8'(i) * stride;
            if (we) begin
                e.a = a;
                e.d = stDataQ[i];
                e.m = mask;
                expStQ.push_back(e);
                refMem[a] = mergeBytes(refMem[a], stDataQ[i], mask);
            end else begin
                expLdAddrQ.push_back(a);
                expLdDataQ.push_back(refMem[a]);
            end
        end
    endtask

    // Per-cycle compare of every SRAM access and every load pop.
    task automatic compareCycle();
        logic   popNow;
        stExp_t e;
        popNow = ld_valid && ld_ready;
        if (!csb0 || !csb1) checkOutput("portExclusive", 32'(csb0 ^ csb1), 32'd1);
        if (!csb0) begin
            checkOutput("stExpected", 32'(expStQ.size() > 0), 32'd1);
            if (expStQ.size() > 0) begin
                e = expStQ.pop_front();
                checkOutput("web0", 32'(web0), 32'd0);
                checkOutput("addr0", 32'(addr0), 32'(e.a));
                checkOutput("din0", din0, e.d);
                checkOutput("wmask0", 32'(wmask0), 32'(e.m));
            end
            stAddrLog.push_back(addr0);
        end
        if (!csb1) begin
            checkOutput("ldIssueExpected", 32'(expLdAddrQ.size() > 0), 32'd1);
            if (expLdAddrQ.size() > 0) checkOutput("addr1", 32'(addr1), 32'(expLdAddrQ.pop_front()));
            checkOutput("credit", 32'((issuedCount - poppedCount - int'(popNow)) < 2), 32'd1);
            ldAddrLog.push_back(addr1);
            issuedCount++;
        end
        if (popNow) begin
            checkOutput("ldExpected", 32'(expLdDataQ.size() > 0), 32'd1);
            if (expLdDataQ.size() > 0) checkOutput("ldData", ld_data, expLdDataQ.pop_front());
            ldDataLog.push_back(ld_data);
            poppedCount++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk0);
            if (rst_n) compareCycle();
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_csb0"}, 32'(csb0), 32'd1);
        checkOutput({tag, "_csb1"}, 32'(csb1), 32'd1);
        checkOutput({tag, "_web0"}, 32'(web0), 32'd1);
        checkOutput({tag, "_wmask0"}, 32'(wmask0), 32'd0);
        checkOutput({tag, "_addr0"}, 32'(addr0), 32'd0);
        checkOutput({tag, "_din0"}, din0, 32'd0);
        checkOutput({tag, "_addr1"}, 32'(addr1), 32'd0);
        checkOutput({tag, "_stReady"}, 32'(st_ready), 32'd0);
        checkOutput({tag, "_ldValid"}, 32'(ld_valid), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_reqReady"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one request, feed store data or wait for the load drain, and
    // check handshake timing and the done pulse.
    task automatic applyStimulus(input logic we, input logic [7:0] base, input logic [7:0] stride,
                                 input int len, input logic [3:0] mask, input logic checkLatency);
        int t;
        @(posedge clk0);
        #1;
        buildExpect(we, base, stride, len, mask);
        checkOutput("reqReady", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_base   = base;
        req_stride = stride;
        req_len    = 6'(len);
        req_wmask  = mask;
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        if (len == 0) begin
            checkOutput("zeroDone", 32'(done), 32'd1);
            @(posedge clk0);
            #1;
            checkOutput("zeroDoneLow", 32'(done), 32'd0);
            return;
        end
        if (we) begin
            for (int i = 0; i < len; i++) begin
                st_valid = 1'b1;
                st_data  = stDataQ[i];
                checkOutput("stReady", 32'(st_ready), 32'd1);
                @(posedge clk0);
                #1;
            end
            st_valid = 1'b0;
            checkOutput("stDone", 32'(done), 32'd1);
            checkOutput("stLeft", 32'(expStQ.size()), 32'd0);
        end else begin
            if (checkLatency) begin
                checkOutput("ldValidC0", 32'(ld_valid), 32'd0);
                @(posedge clk0);
                #1;
                checkOutput("ldValidC1", 32'(ld_valid), 32'd0);
                @(posedge clk0);
                #1;
                checkOutput("ldValidC2", 32'(ld_valid), 32'd1);
            end
            t = 0;
            while (!done && t < 300) begin
                @(posedge clk0);
                #1;
                t++;
            end
            checkOutput("ldDone", 32'(done), 32'd1);
            checkOutput("ldAddrLeft", 32'(expLdAddrQ.size()), 32'd0);
            checkOutput("ldDataLeft", 32'(expLdDataQ.size()), 32'd0);
        end
        @(posedge clk0);
        #1;
        checkOutput("doneLow", 32'(done), 32'd0);
    endtask

    initial begin
        int t;
        nChecks     = 0;
        nPass       = 0;
        issuedCount = 0;
        poppedCount = 0;
        ldReadyMode = 1'b0;
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_base    = '0;
        req_stride  = '0;
        req_len     = '0;
        req_wmask   = '0;
        st_valid    = 1'b0;
        st_data     = '0;
        for (int i = 0; i < 256; i++) begin
            sramMem[i] = 32'hC0DE_0000 | 32'(i);
            refMem[i]  = 32'hC0DE_0000 | 32'(i);
        end

        // Reset with a request and store data pending.
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_len   = 6'd4;
        st_valid  = 1'b1;
        st_data   = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk0);
        #1;
        checkReset("rst");
        req_valid = 1'b0;
        st_valid  = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk0);
        checkOutput("reqReadyAfterRst", 32'(req_ready), 32'd1);

        // Unit-stride store of four elements.
        $display("[TB] store base 0x10 len 4");
        stDataQ = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        stAddrLog.delete();
        applyStimulus(1'b1, 8'h10, 8'h01, 4, 4'hF, 1'b0);
        checkOutput("stAddrCount", 32'(stAddrLog.size()), 32'd4);
        for (int i = 0; i < 4 && i < stAddrLog.size(); i++) begin
            checkOutput("stAddrLit", 32'(stAddrLog[i]), 32'h10 + 32'(i));
            checkOutput("sramLit", sramMem[8'h10 + 8'(i)], 32'hA0 + 32'(i));
        end

        // Load the same region back, checking first-data latency.
        $display("[TB] load base 0x10 len 4");
        ldDataLog.delete();
        applyStimulus(1'b0, 8'h10, 8'h01, 4, 4'h0, 1'b1);
        checkOutput("ldCount", 32'(ldDataLog.size()), 32'd4);
        for (int i = 0; i < 4 && i < ldDataLog.size(); i++) begin
            checkOutput("ldDataLit", ldDataLog[i], 32'hA0 + 32'(i));
        end

        // Negative stride wrapping through address 0.
        $display("[TB] load base 0x01 stride -1 len 3");
        ldAddrLog.delete();
        applyStimulus(1'b0, 8'h01, 8'hFF, 3, 4'h0, 1'b0);
        checkOutput("wrapCount", 32'(ldAddrLog.size()), 32'd3);
        if (ldAddrLog.size() == 3) begin
            checkOutput("wrapAddr0", 32'(ldAddrLog[0]), 32'h01);
            checkOutput("wrapAddr1", 32'(ldAddrLog[1]), 32'h00);
            checkOutput("wrapAddr2", 32'(ldAddrLog[2]), 32'hFF);
        end

        // Eight-element load with a slow consumer.
        $display("[TB] load len 8 with throttled consumer");
        ldDataLog.delete();
        ldReadyMode = 1'b1;
        applyStimulus(1'b0, 8'h10, 8'h01, 8, 4'h0, 1'b0);
        ldReadyMode = 1'b0;
        checkOutput("slowCount", 32'(ldDataLog.size()), 32'd8);
        if (ldDataLog.size() == 8) begin
            checkOutput("slowData0", ldDataLog[0], 32'hA0);
            checkOutput("slowData4", ldDataLog[4], 32'hC0DE_0014);
            checkOutput("slowData7", ldDataLog[7], 32'hC0DE_0017);
        end

        // Zero-length requests, then a partial-byte store read back.
        $display("[TB] zero-length and masked store");
        applyStimulus(1'b1, 8'h40, 8'h01, 0, 4'hF, 1'b0);
        applyStimulus(1'b0, 8'h40, 8'h01, 0, 4'hF, 1'b0);
        stDataQ = '{32'h1234_5678};
        applyStimulus(1'b1, 8'h10, 8'h01, 1, 4'h3, 1'b0);
        checkOutput("maskSram", sramMem[8'h10], 32'h0000_5678);
        ldDataLog.delete();
        applyStimulus(1'b0, 8'h10, 8'h01, 2, 4'h0, 1'b0);
        if (ldDataLog.size() > 0) checkOutput("maskLoad", ldDataLog[0], 32'h0000_5678);

        // Reset in the middle of a five-element load.
        $display("[TB] reset mid-load");
        @(posedge clk0);
        #1;
        poppedCount = 0;
        issuedCount = 0;
        buildExpect(1'b0, 8'h20, 8'h01, 5, 4'h0);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_base   = 8'h20;
        req_stride = 8'h01;
        req_len    = 6'd5;
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        t = 0;
        while (poppedCount < 2 && t < 100) begin
            @(posedge clk0);
            #1;
            t++;
        end
        checkOutput("midPops", 32'(poppedCount >= 2), 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("midRst");
        expLdAddrQ.delete();
        expLdDataQ.delete();
        issuedCount = 0;
        poppedCount = 0;
        repeat (2) @(posedge clk0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk0);
            checkOutput("postRstDone", 32'(done), 32'd0);
            checkOutput("postRstLdValid", 32'(ld_valid), 32'd0);
            checkOutput("postRstReqReady", 32'(req_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
